// File: rtl/regfile_wb_pkg.sv
// Shared types and sizes for the register-file write-side front end.
package regfile_wb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 32;

   typedef struct packed {
      logic                  live;
      logic [REG_ADDR_W-1:0] rw;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of buffered mul/div results with kill-by-address
// and a pending-register mask built from the live entries.
module wb_fifo
   import regfile_wb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic                  push,
   input  wb_entry_t             pushEntry,
   input  logic                  pop,
   input  logic                  killEn,
   input  logic [REG_ADDR_W-1:0] killAddr,
   output wb_entry_t             head,
   output logic                  full,
   output logic                  empty,
   output logic [NUM_REGS-1:0]   pendingMask
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_entry_t        mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] wrPtr;
   logic [CNT_W-1:0] count;

   // Popped slots are marked dead so an unoccupied slot never contributes
   // to the pending mask; a push lands after the kill so it stays live.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (killEn && (mem[i].rw == killAddr)) begin
               mem[i].live <= 1'b0;
            end
         end
         if (pop) begin
            mem[rdPtr].live <= 1'b0;
            rdPtr <= rdPtr + PTR_W'(1);
         end
         if (push) begin
            mem[wrPtr] <= pushEntry;
            wrPtr <= wrPtr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rdPtr];
   assign full  = (count == CNT_W'(FIFO_DEPTH));
   assign empty = (count == '0);

   always_comb begin
      pendingMask = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (mem[i].live) begin
            pendingMask[mem[i].rw] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges pipeline writeback and buffered mul/div results onto the register
// file write port. Optional starvation guard: define WB_STARVE_GUARD_EN.
module regfile_wb_arbiter
   import regfile_wb_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              WbRegWr,
   input  logic [4:0]        WbRW,
   input  logic [DATA_W-1:0] WbBusW,
   input  logic              MdValid,
   output logic              MdReady,
   input  logic [4:0]        MdRW,
   input  logic [DATA_W-1:0] MdBusW,
   output logic              RegWr,
   output logic [4:0]        RW,
   output logic [DATA_W-1:0] BusW,
   output logic [31:0]       PendingMask,
   output logic              StallPipe,
   output logic              Conflict
);

   logic      wbEff;
   logic      push;
   logic      pop;
   logic      headLive;
   logic      fifoFull;
   logic      fifoEmpty;
   wb_entry_t head;
   wb_entry_t pushEntry;

   // Pipeline always wins; the FIFO only drains when the pipeline is idle
   // or targets r0, and a dead head is popped without using the port.
   assign wbEff     = WbRegWr && (WbRW != 5'd0);
   assign MdReady   = !fifoFull;
   assign push      = MdValid && !fifoFull && (MdRW != 5'd0);
   assign pop       = !wbEff && !fifoEmpty;
   assign headLive  = pop && head.live;
   assign pushEntry = '{live: 1'b1, rw: MdRW, data: MdBusW};

   wb_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) uFifo (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .push       (push),
      .pushEntry  (pushEntry),
      .pop        (pop),
      .killEn     (wbEff),
      .killAddr   (WbRW),
      .head       (head),
      .full       (fifoFull),
      .empty      (fifoEmpty),
      .pendingMask(PendingMask)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         RegWr    <= 1'b0;
         RW       <= '0;
         BusW     <= '0;
         Conflict <= 1'b0;
      end else begin
         RegWr <= wbEff || headLive;
         if (wbEff) begin
            RW   <= WbRW;
            BusW <= WbBusW;
         end else if (headLive) begin
            RW   <= head.rw;
            BusW <= head.data;
         end
         if (wbEff && PendingMask[WbRW]) begin
            Conflict <= 1'b1;
         end
      end
   end

`ifdef WB_STARVE_GUARD_EN
   localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);

   logic [SCNT_W-1:0] starveCnt;

   // Counts cycles a live entry waits behind the pipeline; on reaching the
   // limit it asks the pipeline to hold for one cycle so the head drains.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         starveCnt <= '0;
         StallPipe <= 1'b0;
      end else begin
         StallPipe <= 1'b0;
         if (fifoEmpty || pop) begin
            starveCnt <= '0;
         end else if (wbEff && (PendingMask != '0)) begin
            if (starveCnt == SCNT_W'(STARVE_LIMIT - 1)) begin
               starveCnt <= '0;
               StallPipe <= 1'b1;
            end else begin
               starveCnt <= starveCnt + SCNT_W'(1);
            end
         end
      end
   end
`else
   assign StallPipe = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, hand
// sequences for FIFO full/drain, reset and starvation, plus random vs. model.
module tb_regfile_wb_arbiter;

   logic        Clk;
   logic        Rst_n;
   logic        WbRegWr;
   logic [4:0]  WbRW;
   logic [31:0] WbBusW;
   logic        MdValid;
   logic        MdReady;
   logic [4:0]  MdRW;
   logic [31:0] MdBusW;
   logic        RegWr;
   logic [4:0]  RW;
   logic [31:0] BusW;
   logic [31:0] PendingMask;
   logic        StallPipe;
   logic        Conflict;

   int testsRun;
   int testsFailed;

   regfile_wb_arbiter #(
      .DATA_W      (32),
      .FIFO_DEPTH  (4),
      .STARVE_LIMIT(8)
   ) dut (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .WbRegWr    (WbRegWr),
      .WbRW       (WbRW),
      .WbBusW     (WbBusW),
      .MdValid    (MdValid),
      .MdReady    (MdReady),
      .MdRW       (MdRW),
      .MdBusW     (MdBusW),
      .RegWr      (RegWr),
      .RW         (RW),
      .BusW       (BusW),
      .PendingMask(PendingMask),
      .StallPipe  (StallPipe),
      .Conflict   (Conflict)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic        wbRegWr;
      logic [4:0]  wbRW;
      logic [31:0] wbBusW;
      logic        mdValid;
      logic [4:0]  mdRW;
      logic [31:0] mdBusW;
      logic        expRegWr;
      logic [4:0]  expRW;
      logic [31:0] expBusW;
      logic [31:0] expPending;
      logic        expReady;
      logic        expConflict;
   } vector_t;

   typedef struct {
      logic        live;
      logic [4:0]  rw;
      logic [31:0] data;
   } modelEntry_t;

   vector_t     vecs[14];
   modelEntry_t modelQ[$];
   logic        mRegWr;
   logic [4:0]  mRW;
   logic [31:0] mBusW;
   logic        mConflict;

   // Queue-level model: pipeline write wins and kills matching live
   // entries, otherwise the oldest entry leaves (written only if live).
   task automatic modelStep(input logic wbEn, input logic [4:0] wbRw, input logic [31:0] wbData,
                            input logic mdV, input logic [4:0] mdRw, input logic [31:0] mdData);
      modelEntry_t e;
      logic accept;
      accept = mdV && (modelQ.size() < 4);
      if (wbEn && wbRw != 5'd0) begin
         mRegWr = 1'b1;
         mRW    = wbRw;
         mBusW  = wbData;
         foreach (modelQ[i]) begin
            if (modelQ[i].live && modelQ[i].rw == wbRw) begin
               modelQ[i].live = 1'b0;
               mConflict = 1'b1;
            end
         end
      end else if (modelQ.size() > 0) begin
         e = modelQ.pop_front();
         mRegWr = e.live;
         if (e.live) begin
            mRW   = e.rw;
            mBusW = e.data;
         end
      end else begin
         mRegWr = 1'b0;
      end
      if (accept && mdRw != 5'd0) begin
         e.live = 1'b1;
         e.rw   = mdRw;
         e.data = mdData;
         modelQ.push_back(e);
      end
   endtask

   function automatic logic [31:0] modelPending();
      logic [31:0] m;
      m = '0;
      foreach (modelQ[i]) begin
         if (modelQ[i].live) m[modelQ[i].rw] = 1'b1;
      end
      return m;
   endfunction

   task automatic modelReset();
      modelQ.delete();
      mRegWr    = 1'b0;
      mRW       = '0;
      mBusW     = '0;
      mConflict = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives one cycle of inputs, then lets the edge pass and settles.
   task automatic applyStimulus(input logic wbEn, input logic [4:0] wbRw, input logic [31:0] wbData,
                                input logic mdV, input logic [4:0] mdRw, input logic [31:0] mdData);
      WbRegWr = wbEn;
      WbRW    = wbRw;
      WbBusW  = wbData;
      MdValid = mdV;
      MdRW    = mdRw;
      MdBusW  = mdData;
      @(posedge Clk);
      #1;
   endtask

   task automatic doReset();
      WbRegWr = 1'b0;
      WbRW    = '0;
      WbBusW  = '0;
      MdValid = 1'b0;
      MdRW    = '0;
      MdBusW  = '0;
      #2;
      Rst_n = 1'b0;
      #2;
      checkOutput("rst_regwr", RegWr, 0);
      checkOutput("rst_rw", RW, 0);
      checkOutput("rst_busw", BusW, 0);
      checkOutput("rst_pending", PendingMask, 0);
      checkOutput("rst_ready", MdReady, 1);
      checkOutput("rst_conflict", Conflict, 0);
      checkOutput("rst_stall", StallPipe, 0);
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      modelReset();
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      Rst_n       = 1'b0;

      vecs[0]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        32'h0,   1'b1, 1'b0};
      vecs[1]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        32'h20,  1'b1, 1'b0};
      vecs[2]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'hDEADBEEF, 32'h0,   1'b1, 1'b0};
      vecs[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 32'hDEADBEEF, 32'h0,   1'b1, 1'b0};
      vecs[4]  = '{1'b1, 5'd0, 32'h1234, 1'b1, 5'd3, 32'h33,    1'b0, 5'd5, 32'hDEADBEEF, 32'h8,   1'b1, 1'b0};
      vecs[5]  = '{1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 32'h0,     1'b1, 5'd3, 32'h33,       32'h0,   1'b1, 1'b0};
      vecs[6]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77,       1'b0, 5'd3, 32'h33,       32'h80,  1'b1, 1'b0};
      vecs[7]  = '{1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 32'h0,       1'b1, 5'd7, 32'h11,       32'h0,   1'b1, 1'b1};
      vecs[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 32'h11,       32'h0,   1'b1, 1'b1};
      vecs[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 32'h11,       32'h0,   1'b1, 1'b1};
      vecs[10] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hAA,       1'b0, 5'd7, 32'h11,       32'h0,   1'b1, 1'b1};
      vecs[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 32'h11,       32'h0,   1'b1, 1'b1};
      vecs[12] = '{1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h98,      1'b1, 5'd9, 32'h99,       32'h200, 1'b1, 1'b1};
      vecs[13] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h98,       32'h0,   1'b1, 1'b1};

      doReset();

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].wbRegWr, vecs[i].wbRW, vecs[i].wbBusW,
                       vecs[i].mdValid, vecs[i].mdRW, vecs[i].mdBusW);
         checkOutput($sformatf("vec%0d_regwr", i), RegWr, vecs[i].expRegWr);
         checkOutput($sformatf("vec%0d_rw", i), RW, vecs[i].expRW);
         checkOutput($sformatf("vec%0d_busw", i), BusW, vecs[i].expBusW);
         checkOutput($sformatf("vec%0d_pending", i), PendingMask, vecs[i].expPending);
         checkOutput($sformatf("vec%0d_ready", i), MdReady, vecs[i].expReady);
         checkOutput($sformatf("vec%0d_conflict", i), Conflict, vecs[i].expConflict);
      end

      // FIFO fills behind a busy pipeline, then drains in acceptance order.
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b1, 5'd20, 32'h100 + c, 1'b1, 5'(c + 1), 32'hA0 + c);
         checkOutput($sformatf("fill%0d_ready", c), MdReady, (c < 3) ? 1 : 0);
         checkOutput($sformatf("fill%0d_rw", c), RW, 20);
      end
      applyStimulus(1'b1, 5'd20, 32'h104, 1'b1, 5'd5, 32'hA4);
      checkOutput("fill5_ready", MdReady, 0);
      checkOutput("fill5_pending", PendingMask, 32'h1E);
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
         checkOutput($sformatf("drain%0d_regwr", k), RegWr, 1);
         checkOutput($sformatf("drain%0d_rw", k), RW, k);
         checkOutput($sformatf("drain%0d_busw", k), BusW, 32'hA0 + k - 1);
         checkOutput($sformatf("drain%0d_ready", k), MdReady, 1);
      end
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("drained_regwr", RegWr, 0);
      checkOutput("drained_pending", PendingMask, 0);

      // Randomised traffic against the queue model.
      doReset();
      for (int n = 0; n < 400; n++) begin
         logic        rWb;
         logic [4:0]  rWbRw;
         logic [31:0] rWbData;
         logic        rMd;
         logic [4:0]  rMdRw;
         logic [31:0] rMdData;
         rWb     = ($urandom_range(0, 99) < 55);
         rWbRw   = 5'($urandom_range(0, 7));
         rWbData = $urandom;
         rMd     = ($urandom_range(0, 99) < 50);
         rMdRw   = 5'($urandom_range(0, 7));
         rMdData = $urandom;
         applyStimulus(rWb, rWbRw, rWbData, rMd, rMdRw, rMdData);
         modelStep(rWb, rWbRw, rWbData, rMd, rMdRw, rMdData);
         checkOutput($sformatf("rnd%0d_regwr", n), RegWr, mRegWr);
         checkOutput($sformatf("rnd%0d_rw", n), RW, mRW);
         checkOutput($sformatf("rnd%0d_busw", n), BusW, mBusW);
         checkOutput($sformatf("rnd%0d_pending", n), PendingMask, modelPending());
         checkOutput($sformatf("rnd%0d_ready", n), MdReady, (modelQ.size() < 4) ? 1 : 0);
         checkOutput($sformatf("rnd%0d_conflict", n), Conflict, mConflict);
`ifndef WB_STARVE_GUARD_EN
         checkOutput($sformatf("rnd%0d_stall", n), StallPipe, 0);
`endif
      end

      // Reset while entries are buffered: they must never be written.
      applyStimulus(1'b1, 5'd20, 32'h1, 1'b1, 5'd10, 32'h10);
      applyStimulus(1'b1, 5'd21, 32'h2, 1'b1, 5'd11, 32'h11);
      #2;
      Rst_n = 1'b0;
      #2;
      checkOutput("midrst_pending", PendingMask, 0);
      checkOutput("midrst_ready", MdReady, 1);
      checkOutput("midrst_regwr", RegWr, 0);
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      modelReset();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
         checkOutput($sformatf("postrst%0d_regwr", k), RegWr, 0);
      end

`ifdef WB_STARVE_GUARD_EN
      // One live entry waits behind eight pipeline-won cycles.
      doReset();
      applyStimulus(1'b1, 5'd20, 32'h300, 1'b1, 5'd12, 32'hC12);
      for (int k = 1; k <= 8; k++) begin
         checkOutput($sformatf("starve%0d_stall", k), StallPipe, 0);
         applyStimulus(1'b1, 5'd20, 32'h300 + k, 1'b0, 5'd0, 32'h0);
      end
      checkOutput("starve9_stall", StallPipe, 1);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("starve10_regwr", RegWr, 1);
      checkOutput("starve10_rw", RW, 12);
      checkOutput("starve10_busw", BusW, 32'hC12);
      checkOutput("starve10_stall", StallPipe, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
